clock_divider_bank: RTL
=======================

// Module: clock_divider_bank
//
// PURPOSE
//  N-channel programmable clock divider; successor to the fixed mod-k counter + toggle pairs.
//  Each channel produces a one-cycle tick and a 50%-duty square wave at f_clk/(2*div).
//  Divisors are reloadable at runtime through a write port. Channels are enabled individually.
//  Sits between the board clock and LED/display/timer logic. All outputs are registered in the clk domain.
//
// PARAMETERS
//  N_CH        4           number of divider channels (1..16)
//  W           28          divisor/counter width in bits
//  DEFAULT_DIV 25_000_000  divisor loaded into every channel at reset (1 Hz wave @ 50 MHz)
//
// PORTS
//  clk      in   1                  system clock (MAX10_CLK1_50 at top level)
//  reset    in   1                  asynchronous reset, active-high
//  en       in   N_CH               per-channel run enable
//  wr_en    in   1                  divisor write strobe, one cycle
//  wr_ch    in   $clog2(N_CH)>0?:1  target channel of write
//  wr_div   in   W                  new divisor value
//  tick     out  N_CH               1-cycle pulse per channel at counter wrap
//  wave     out  N_CH               square wave per channel; toggles on each tick
//  busy     out  N_CH               1 = shadow divisor pending, not yet active
//
// BEHAVIOUR
//  Per-channel state: cnt[W], act_div[W] (active divisor), shd_div[W] (shadow divisor).
//  reset (async): cnt=0, act_div=shd_div=DEFAULT_DIV, tick=0, wave=0, busy=0.
//  Effective divisor eff = (act_div==0) ? 1 : act_div. Divisor 0 behaves as 1.
//  en=1, cnt==eff-1 (wrap): cnt<=0, tick<=1, wave<=~wave, act_div<=shd_div, busy<=0.
//  en=1, no wrap: cnt<=cnt+1, tick<=0.
//  en=0: cnt<=0, tick<=0, wave holds, act_div<=shd_div, busy<=0.
//  After en rises: first tick after eff cycles; tick period = eff cycles; wave period = 2*eff.
//  eff==1: tick is high continuously and wave toggles every cycle.
//  Write (wr_en=1, wr_ch<N_CH): shd_div[wr_ch]<=wr_div, busy[wr_ch]<=1 on the next edge.
//  Write with wr_ch>=N_CH: ignored. No state changes.
//  Write in the same cycle as a wrap on that channel: act_div<=wr_div directly (bypass), busy<=0.
//  Write in the same cycle as en=0 on that channel: act_div<=wr_div, busy<=0.
//  A divisor change never truncates or extends the current period. The new value applies from the next period.
//  Multiple writes before a wrap: the last write wins.
//  Counter arithmetic is W-bit unsigned. cnt never exceeds eff-1, so no wrap past 2^W.
//  Latency: the tick register is high in the cycle after cnt==eff-1 is sampled. The wave edge coincides with the tick rising.
//
// CONFIGURATION
//  CLKDIV_PHASE_SYNC_EN defined:
//    Adds input port sync (1 bit). sync=1 forces every channel to cnt<=0, tick<=0, wave<=0, act_div<=shd_div, busy<=0.
//    sync has priority over wrap, write-bypass and en.
//    A write in the same cycle as sync still updates shd_div, and busy<=1.
//    Use: phase-align all channels.
//  CLKDIV_PHASE_SYNC_EN undefined:
//    Port absent. Channels are aligned only by reset or by en toggling.
//
// TESTING
//  1. reset, en=all 1, N_CH=4, all channels at DEFAULT_DIV=4 (bench override)
//     -> tick every 4 cycles, wave period 8, all channels in phase.
//  2. wr_ch=1, wr_div=3 mid-period -> busy[1]=1.
//     The current 4-cycle period completes, then ticks arrive every 3 cycles and busy[1] drops at the wrap.
//  3. wr_div=0 and wr_div=1 on ch0 -> after the next wrap, tick[0] is constant 1 and wave[0] toggles each cycle.
//  4. en[2]=0 for 5 cycles, then 1 -> tick[2]=0 and wave[2] held while disabled.
//     The first tick comes eff cycles after en rises.
//  5. wr_ch=N_CH (out of range) -> no change to any shd_div, busy or output.
//     Also: a write coincident with a wrap takes effect immediately.
//  6. CLKDIV_PHASE_SYNC_EN defined: sync pulse with channels at divisors 3/5/7
//     -> all wave=0, cnt=0, then first ticks at +3/+5/+7 cycles.
//     Also: assert reset mid-period -> outputs reset asynchronously.

Source files
------------

// File: rtl/clock_divider_bank_if.sv
// Purpose: control/status bundle of clock_divider_bank (enables, divisor write port, tick/wave/busy).
// Latency: none, wires only.
// Backpressure: none; the write port is a single-cycle strobe that is always accepted.
//
// Signals:
//   en      per-channel run enable
//   wr_en   divisor write strobe (one cycle)
//   wr_ch   target channel of a write
//   wr_div  new divisor value
//   tick    one-cycle pulse per channel at counter wrap
//   wave    50% duty square wave per channel
//   busy    shadow divisor pending per channel
//   sync    phase-align strobe, present only with CLKDIV_PHASE_SYNC_EN
interface clock_divider_bank_if #(
    parameter int N_CH = 4,
    parameter int W    = 28
);
    localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [N_CH-1:0] en;
    logic            wr_en;
    logic [CHW-1:0]  wr_ch;
    logic [W-1:0]    wr_div;
    logic [N_CH-1:0] tick;
    logic [N_CH-1:0] wave;
    logic [N_CH-1:0] busy;
`ifdef CLKDIV_PHASE_SYNC_EN
    logic            sync;

    modport master (
        output en, wr_en, wr_ch, wr_div, sync,
        input  tick, wave, busy
    );
    modport slave (
        input  en, wr_en, wr_ch, wr_div, sync,
        output tick, wave, busy
    );
`else
    modport master (
        output en, wr_en, wr_ch, wr_div,
        input  tick, wave, busy
    );
    modport slave (
        input  en, wr_en, wr_ch, wr_div,
        output tick, wave, busy
    );
`endif
endinterface

// File: rtl/clock_divider_bank.sv
// Purpose: N-channel programmable clock divider; per channel a one-cycle tick and a
//          50% square wave at f_clk/(2*div), divisors reloadable at runtime.
// Latency: tick/wave are registered, high the cycle after cnt==eff-1 is sampled.
// Backpressure: none; writes are always accepted, out-of-range channel writes dropped.
//
// Ports:
//   clk    system clock
//   reset  asynchronous reset, active-high
//   bus    clock_divider_bank_if.slave (en, wr_en, wr_ch, wr_div -> tick, wave, busy)
//
// Optional feature macro: CLKDIV_PHASE_SYNC_EN adds bus.sync, which forces every
// channel back to phase zero (cnt=0, wave=0) and loads the shadow divisors.
module clock_divider_bank #(
    parameter int           N_CH        = 4,
    parameter int           W           = 28,
    parameter logic [W-1:0] DEFAULT_DIV = W'(25_000_000)
) (
    input  logic                  clk,
    input  logic                  reset,
    clock_divider_bank_if.slave   bus
);

    logic [W-1:0]    cnt_q [N_CH];
    logic [W-1:0]    cnt_d [N_CH];
    logic [W-1:0]    act_q [N_CH];
    logic [W-1:0]    act_d [N_CH];
    logic [W-1:0]    shd_q [N_CH];
    logic [W-1:0]    shd_d [N_CH];
    logic [N_CH-1:0] tick_q, tick_d;
    logic [N_CH-1:0] wave_q, wave_d;
    logic [N_CH-1:0] busy_q, busy_d;

    logic [W-1:0]    eff [N_CH];
    logic [N_CH-1:0] wrap;
    logic [N_CH-1:0] wr_hit;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        // A zero divisor would never wrap; treat it as divide-by-one.
        assign eff[g]    = (act_q[g] == '0) ? W'(1) : act_q[g];
        assign wrap[g]   = bus.en[g] && (cnt_q[g] == eff[g] - W'(1));
        // Only channel indices below N_CH exist, so an out-of-range wr_ch matches nothing.
        assign wr_hit[g] = bus.wr_en && (int'(bus.wr_ch) == g);
    end

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i]  = cnt_q[i];
            act_d[i]  = act_q[i];
            shd_d[i]  = shd_q[i];
            tick_d[i] = 1'b0;
            wave_d[i] = wave_q[i];
            busy_d[i] = busy_q[i];

            if (wr_hit[i]) begin
                shd_d[i]  = bus.wr_div;
                busy_d[i] = 1'b1;
            end

            // Period boundary (wrap) or idle channel: the pending divisor becomes active.
            // A write landing in that same cycle bypasses the shadow so it is not lost
            // for a whole period.
            if (!bus.en[i] || wrap[i]) begin
                cnt_d[i]  = '0;
                act_d[i]  = wr_hit[i] ? bus.wr_div : shd_q[i];
                busy_d[i] = 1'b0;
                if (wrap[i]) begin
                    tick_d[i] = 1'b1;
                    wave_d[i] = ~wave_q[i];
                end
            end else begin
                cnt_d[i] = cnt_q[i] + W'(1);
            end

`ifdef CLKDIV_PHASE_SYNC_EN
            // sync overrides wrap, bypass and en; a coincident write still lands in
            // the shadow and stays pending.
            if (bus.sync) begin
                cnt_d[i]  = '0;
                tick_d[i] = 1'b0;
                wave_d[i] = 1'b0;
                act_d[i]  = shd_q[i];
                busy_d[i] = wr_hit[i];
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
                act_q[i] <= DEFAULT_DIV;
                shd_q[i] <= DEFAULT_DIV;
            end
            tick_q <= '0;
            wave_q <= '0;
            busy_q <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
                act_q[i] <= act_d[i];
                shd_q[i] <= shd_d[i];
            end
            tick_q <= tick_d;
            wave_q <= wave_d;
            busy_q <= busy_d;
        end
    end

    assign bus.tick = tick_q;
    assign bus.wave = wave_q;
    assign bus.busy = busy_q;

endmodule
